mem_arbiter: RTL

Arbitrates a single shared backing-memory port between the instruction-side refill requester and the data-side requester of the L1 cache pair in the 5-stage RISC-V pipeline. Instruction requests are always line-refill read bursts. Data requests are either line-refill read bursts or single-word write-through stores. The data side has fixed priority, and a streak limit bounds instruction starvation. Each transaction is sequenced by an IDLE/BUSY/DONE state machine with registered read-data return and a one-cycle done pulse that the stall control uses to release the pipeline.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package : mem_arb_pkg
// Shared types and helpers for the I/D backing-memory port arbiter.
// Rev     : 1.0
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Byte-offset bits inside one aligned refill line (word offset + 2 byte bits).
    function automatic int line_off_bits(input int block_words);
        return $clog2(block_words) + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_arbiter
// Fixed-priority (data first, streak-bounded) arbiter sequencing refill bursts
// and write-through stores onto a single backing-memory port.
// Rev    : 1.0
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int BLOCK_WORDS  = 4,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int c_BEAT_W    = $clog2(BLOCK_WORDS);
    localparam int c_LINE_BITS = line_off_bits(BLOCK_WORDS);
    localparam int c_STREAK_W  = $clog2(MAX_D_STREAK + 1);

    localparam logic [c_BEAT_W-1:0]   c_LAST_BEAT  = c_BEAT_W'(BLOCK_WORDS - 1);
    localparam logic [c_BEAT_W-1:0]   c_BEAT_ONE   = c_BEAT_W'(1);
    localparam logic [c_STREAK_W-1:0] c_MAX_STREAK = c_STREAK_W'(MAX_D_STREAK);
    localparam logic [c_STREAK_W-1:0] c_STREAK_ONE = c_STREAK_W'(1);
    localparam logic [ADDR_W-1:0]     c_LINE_MASK  = {ADDR_W{1'b1}} << c_LINE_BITS;
    localparam logic [ADDR_W-1:0]     c_WORD_MASK  = {ADDR_W{1'b1}} << 2;

    state_t              state_q;
    logic                owner_q;
    logic                is_write_q;
    logic [ADDR_W-1:0]   base_q;
    logic [c_BEAT_W-1:0] beat_q;
    logic [c_STREAK_W-1:0] streak_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   i_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;
    logic                i_rvalid_q;
    logic                d_rvalid_q;
    logic                i_done_q;
    logic                d_done_q;

    logic              w_d_wins;
    logic              w_req_we;
    logic [ADDR_W-1:0] w_req_addr;
    logic [ADDR_W-1:0] w_beat_off;

    // Data side wins unless the instruction side has waited out a full streak.
    assign w_d_wins   = d_req && (!i_req || (streak_q < c_MAX_STREAK));
    assign w_req_we   = w_d_wins && d_we;
    assign w_req_addr = w_d_wins ? d_addr : i_addr;
    assign w_beat_off = ADDR_W'({beat_q, 2'b00});

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_I;
            is_write_q <= 1'b0;
            base_q     <= '0;
            beat_q     <= '0;
            streak_q   <= '0;
            wdata_q    <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
        end else begin
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_req || d_req) begin
                        owner_q    <= w_d_wins ? OWN_D : OWN_I;
                        is_write_q <= w_req_we;
                        wdata_q    <= d_wdata;
                        base_q     <= w_req_addr & (w_req_we ? c_WORD_MASK : c_LINE_MASK);
                        beat_q     <= '0;
                        streak_q   <= (w_d_wins && i_req) ? streak_q + c_STREAK_ONE : '0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        if (!is_write_q) begin
                            if (owner_q == OWN_D) begin
                                d_rdata_q  <= mem_rdata;
                                d_rvalid_q <= 1'b1;
                            end else begin
                                i_rdata_q  <= mem_rdata;
                                i_rvalid_q <= 1'b1;
                            end
                        end
                        beat_q <= beat_q + c_BEAT_ONE;
                        if (is_write_q || (beat_q == c_LAST_BEAT)) begin
                            state_q  <= DONE;
                            d_done_q <= (owner_q == OWN_D);
                            i_done_q <= (owner_q == OWN_I);
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i_gnt     = (state_q == BUSY) && (owner_q == OWN_I);
    assign d_gnt     = (state_q == BUSY) && (owner_q == OWN_D);
    assign mem_req   = (state_q == BUSY);
    assign mem_we    = (state_q == BUSY) && is_write_q;
    assign mem_addr  = base_q + w_beat_off;
    assign mem_wdata = wdata_q;
    assign i_rvalid  = i_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;

endmodule
`default_nettype wire
